fill_rect: RTL

FILL_RECT -- requirements
Module: fill_rect

---
 rtl/fill_rect.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/fill_rect.sv
// fill_rect: AXI4 write master that paints a clipped rectangle of 64-byte blocks with one colour.
// Control: START/BUSY/DONE/ERR plus the rectangle (BASEADDR, XBLK, WBLK, YPOS, HEIGHT, COLOR).
// Memory: AXI4 write channels (AW/W/B), one 16-beat INCR burst per block; read channel tied off.
module fill_rect #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int LINE_BYTES         = 2048
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic                            START,
  input  logic [27:0]                     BASEADDR,
  input  logic [4:0]                      XBLK,
  input  logic [5:0]                      WBLK,
  input  logic [9:0]                      YPOS,
  input  logic [9:0]                      HEIGHT,
  input  logic [15:0]                     COLOR,
  output logic                            BUSY,
  output logic                            DONE,
  output logic                            ERR,
  output logic [0:0]                      M_AXI_AWID,
  output logic [31:0]                     M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWLOCK,
  output logic [3:0]                      M_AXI_AWCACHE,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic [3:0]                      M_AXI_AWQOS,
  output logic [0:0]                      M_AXI_AWUSER,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic [0:0]                      M_AXI_WUSER,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [0:0]                      M_AXI_BID,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic [0:0]                      M_AXI_BUSER,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [0:0]                      M_AXI_ARID,
  output logic [31:0]                     M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARLOCK,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic [3:0]                      M_AXI_ARQOS,
  output logic [0:0]                      M_AXI_ARUSER,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [0:0]                      M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic [0:0]                      M_AXI_RUSER,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam logic [2:0] S_IDLE = 3'd0, S_AW = 3'd1, S_W = 3'd2, S_B = 3'd3, S_NEXT = 3'd4;
  logic [2:0]  state_q, state_d;
  logic [5:0]  bi_q, bi_d, nb_q, nb_in;
  logic [9:0]  ri_q, ri_d, nr_q, nr_in;
  logic [3:0]  beat_q, beat_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [27:0] base_q;
  logic [4:0]  xblk_q, col;
  logic [9:0]  ypos_q, row;
  logic [15:0] color_q;
  logic [10:0] room_r;
  logic        accept, empty, last, unused;
  // Clipping is folded into the latched block/row counts so the walk never visits off-screen blocks.
  assign nb_in  = (WBLK < 6'd32 - {1'b0, XBLK}) ? WBLK : 6'd32 - {1'b0, XBLK};
  assign room_r = (YPOS > 10'd767) ? 11'd0 : 11'd768 - {1'b0, YPOS};
  assign nr_in  = ({1'b0, HEIGHT} < room_r) ? HEIGHT : room_r[9:0];
  assign accept = START && state_q == S_IDLE;
  assign empty  = nb_q == 6'd0 || nr_q == 10'd0;
  assign last   = bi_q == nb_q - 6'd1 && ri_q == nr_q - 10'd1;
  assign col    = xblk_q + bi_q[4:0];
  assign row    = ypos_q + ri_q;
  assign M_AXI_AWADDR  = {4'h0, base_q} + 32'(row) * 32'(LINE_BYTES) + {21'd0, col, 6'd0};
  assign M_AXI_AWVALID = state_q == S_AW;
  assign M_AXI_WVALID  = state_q == S_W;
  assign M_AXI_WLAST   = M_AXI_WVALID && beat_q == 4'hF;
  assign M_AXI_WDATA   = {color_q, color_q};
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWLEN   = 8'd15;
  assign M_AXI_AWSIZE  = 3'b010;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWQOS   = '0;
  assign M_AXI_AWUSER  = '0;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WUSER   = '0;
  assign M_AXI_BREADY  = 1'b1;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = '0;
  assign M_AXI_ARLEN   = '0;
  assign M_AXI_ARSIZE  = '0;
  assign M_AXI_ARBURST = '0;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = '0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARQOS   = '0;
  assign M_AXI_ARUSER  = '0;
  assign M_AXI_ARVALID = 1'b0;
  assign M_AXI_RREADY  = 1'b0;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign ERR  = err_q;
  assign unused = ^{M_AXI_BID, M_AXI_BUSER, M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA,
                    M_AXI_RRESP, M_AXI_RLAST, M_AXI_RUSER, M_AXI_RVALID};
  always_comb begin
    state_d = state_q;
    bi_d    = bi_q;
    ri_d    = ri_q;
    beat_d  = beat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (START) begin
        // An empty rectangle still passes through NEXT so DONE lands two cycles after START.
        state_d = (nb_in == 6'd0 || nr_in == 10'd0) ? S_NEXT : S_AW;
        busy_d  = 1'b1;
        err_d   = 1'b0;
        bi_d    = '0;
        ri_d    = '0;
        beat_d  = '0;
      end
      S_AW: state_d = M_AXI_AWREADY ? S_W : S_AW;
      S_W: if (M_AXI_WREADY) begin
        beat_d  = beat_q + 4'd1;
        state_d = beat_q == 4'hF ? S_B : S_W;
      end
      // DONE is raised on leaving B so it appears the cycle after the final response.
      S_B: if (M_AXI_BVALID) begin
        state_d = S_NEXT;
        err_d   = err_q | (|M_AXI_BRESP);
        done_d  = last;
        busy_d  = !last;
      end
      S_NEXT: begin
        state_d = (empty || last) ? S_IDLE : S_AW;
        done_d  = empty;
        busy_d  = busy_q && !empty;
        bi_d    = (bi_q == nb_q - 6'd1) ? 6'd0 : bi_q + 6'd1;
        ri_d    = (bi_q == nb_q - 6'd1) ? ri_q + 10'd1 : ri_q;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      bi_q    <= '0;
      ri_q    <= '0;
      beat_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bi_q    <= bi_d;
      ri_q    <= ri_d;
      beat_q  <= beat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      base_q  <= '0;
      xblk_q  <= '0;
      ypos_q  <= '0;
      color_q <= '0;
      nb_q    <= '0;
      nr_q    <= '0;
    end else if (accept) begin
      base_q  <= BASEADDR;
      xblk_q  <= XBLK;
      ypos_q  <= YPOS;
      color_q <= COLOR;
      nb_q    <= nb_in;
      nr_q    <= nr_in;
    end
  end
endmodule
